overflow_accumulator: RTL and testbench
=======================================

OVERFLOW_ACCUMULATOR -- requirements
Module: overflow_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: data and accumulator width in bits, legal range 2..32.
REQ-002 Parameter SIGNED, default 0: 0 selects unsigned overflow detection (carry out), 1 selects two's-complement overflow detection.
REQ-003 Parameter SATURATE, default 0: 0 wraps on overflow, 1 clamps to the representable limit.
REQ-004 Parameter CNT_W, default 8: width of the overflow event counter, legal range 1..16.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; clk is the only clock, rst is the reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  accumulate d into q this cycle.
REQ-009 clr  input  1  synchronous clear of q, the sticky flag and the counter.
REQ-010 d  input  WIDTH  addend, interpreted per SIGNED.
REQ-011 q  output  WIDTH  registered accumulator value.
REQ-012 overflow  output  1  one-cycle pulse, registered, marking an overflowing add.
REQ-013 overflow_sticky  output  1  set by any overflow, held until clr or rst.
REQ-014 ovf_count  output  CNT_W  saturating count of overflow events.

Function
REQ-015 The add SHALL be computed as sum = q + d at WIDTH+1 bits; all outputs SHALL be registered, so latency is 1 cycle from d/en to q, overflow, overflow_sticky and ovf_count.
REQ-016 For SIGNED=0, overflow SHALL be sum[WIDTH], the carry out.
REQ-017 For SIGNED=1, overflow SHALL be asserted when q and d have equal MSBs and sum[WIDTH-1] differs from them; a carry out alone SHALL NOT flag.
REQ-018 For SATURATE=0, q SHALL take sum[WIDTH-1:0] on every enabled add, whether or not it overflows.
REQ-019 For SATURATE=1 with no overflow, q SHALL take sum[WIDTH-1:0]. On overflow, q SHALL take all-ones (unsigned), 0 then all-ones (signed, positive overflow), or 1 then all-zeros (signed, negative overflow).
REQ-020 The overflow pulse SHALL be high for exactly the one cycle after the offending enabled add; back-to-back overflowing adds SHALL keep overflow high on consecutive cycles.
REQ-021 When en=0 and clr=0, q, overflow_sticky and ovf_count SHALL hold and overflow SHALL be 0.
REQ-022 overflow_sticky SHALL be set in the same cycle that overflow is asserted.
REQ-023 ovf_count SHALL increment by 1 per overflow event and stop at 2^CNT_W-1 without wrapping.
REQ-024 clr=1 SHALL take priority over en. In the next cycle q, overflow, overflow_sticky and ovf_count SHALL all be 0, and d SHALL be discarded.
REQ-025 rst SHALL take priority over clr and en.

Reset
REQ-026 While rst=1 at a rising clk edge, the next cycle SHALL show q=0, overflow=0, overflow_sticky=0 and ovf_count=0.
REQ-027 Reset asserted mid-accumulation SHALL discard the in-flight add. The first enabled add after rst deasserts SHALL use q=0.

Verification
REQ-028 Unsigned wrap (WIDTH=8, SIGNED=0, SATURATE=0): en with d=0xF0 then d=0x20 -> q=0xF0, then q=0x10 with overflow=1 for one cycle, sticky=1, count=1.
REQ-029 Unsigned saturate (SATURATE=1): same stimulus -> q=0xF0, then q=0xFF with overflow=1; a further d=0x01 -> q=0xFF, overflow=1, count=2.
REQ-030 Signed, SATURATE=0: d=0x7F then d=0x01 -> q=0x80 with overflow=1. Separately from q=0x80, d=0x7F -> q=0xFF with overflow=0.
REQ-031 Signed, SATURATE=1: from q=0x7F, d=0x01 -> q=0x7F with overflow=1. From q=0x80, d=0xFF -> q=0x80 with overflow=1.
REQ-032 Counter saturation (CNT_W=2): 5 consecutive overflowing adds -> overflow high 5 cycles, ovf_count 1,2,3,3,3, sticky stays 1.
REQ-033 clr/rst precedence: clr=1 and en=1 with d=0x55 while sticky=1 -> q=0, sticky=0, count=0, overflow=0. rst=1 together with clr=0, en=1 -> all outputs 0.

Source files
------------

// File: rtl/overflow_accumulator.sv
// overflow_accumulator: registered accumulator with wrap/saturate overflow handling and event tracking
// Ports: clk/rst clock and sync active-high reset; en accumulates d; clr zeroes all state;
//        q accumulator; overflow one-cycle pulse; overflow_sticky held flag; ovf_count saturating event count
module overflow_accumulator #(
    parameter int WIDTH    = 8,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             overflow,
    output logic             overflow_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] q_next;
    always_comb begin
        sum     = {1'b0, q} + {1'b0, d};
        ovf     = (SIGNED != 0) ? (q[WIDTH-1] == d[WIDTH-1]) && (sum[WIDTH-1] != q[WIDTH-1]) : sum[WIDTH];
        // signed overflow direction follows the shared operand sign
        sat_val = (SIGNED == 0) ? '1 : q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        q_next  = (SATURATE != 0 && ovf) ? sat_val : sum[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q               <= '0;
            overflow        <= 1'b0;
            overflow_sticky <= 1'b0;
            ovf_count       <= '0;
        end else begin
            overflow <= en && ovf;
            if (en) begin
                q <= q_next;
                if (ovf) begin
                    overflow_sticky <= 1'b1;
                    if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_overflow_accumulator.sv
// tb_overflow_accumulator: four parameter variants driven in parallel, checked against an arithmetic model
// Instances: 0 unsigned/wrap/CNT_W=8, 1 unsigned/saturate/CNT_W=2, 2 signed/wrap/CNT_W=8, 3 signed/saturate/CNT_W=2
module tb_overflow_accumulator;
    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [7:0] d;
    logic [7:0] dq [4];
    logic       dov [4];
    logic       dst [4];
    logic [7:0] dc0, dc2;
    logic [1:0] dc1, dc3;
    logic [7:0] dc [4];
    logic [7:0] mq [4];
    logic [7:0] mc [4];
    logic       mo [4];
    logic       ms [4];
    int         errs = 0;
    int         checks = 0;
    logic       chk_on = 1'b0;
    always #5 clk = ~clk;
    overflow_accumulator #(.WIDTH(8), .SIGNED(0), .SATURATE(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
        .q(dq[0]), .overflow(dov[0]), .overflow_sticky(dst[0]), .ovf_count(dc0));
    overflow_accumulator #(.WIDTH(8), .SIGNED(0), .SATURATE(1), .CNT_W(2)) u1 (.clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
        .q(dq[1]), .overflow(dov[1]), .overflow_sticky(dst[1]), .ovf_count(dc1));
    overflow_accumulator #(.WIDTH(8), .SIGNED(1), .SATURATE(0), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
        .q(dq[2]), .overflow(dov[2]), .overflow_sticky(dst[2]), .ovf_count(dc2));
    overflow_accumulator #(.WIDTH(8), .SIGNED(1), .SATURATE(1), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .en(en), .clr(clr), .d(d),
        .q(dq[3]), .overflow(dov[3]), .overflow_sticky(dst[3]), .ovf_count(dc3));
    always_comb begin
        dc[0] = dc0;
        dc[1] = {6'b0, dc1};
        dc[2] = dc2;
        dc[3] = {6'b0, dc3};
    end
    function automatic bit is_sgn(int k);
        return k >= 2;
    endfunction
    function automatic bit is_sat(int k);
        return k == 1 || k == 3;
    endfunction
    function automatic int cmax(int k);
        return (k == 1 || k == 3) ? 3 : 255;
    endfunction
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int s, lo, hi;
            bit o;
            lo = is_sgn(k) ? -128 : 0;
            hi = is_sgn(k) ? 127 : 255;
            s  = is_sgn(k) ? int'($signed(mq[k])) + int'($signed(d)) : int'(mq[k]) + int'(d);
            o  = s > hi || s < lo;
            if (rst || clr) begin
                mq[k] <= 8'h00;
                mo[k] <= 1'b0;
                ms[k] <= 1'b0;
                mc[k] <= 8'h00;
            end else if (en) begin
                mo[k] <= o;
                if (o && is_sat(k)) mq[k] <= (s > hi) ? hi[7:0] : lo[7:0];
                else mq[k] <= s[7:0];
                if (o) begin
                    ms[k] <= 1'b1;
                    if (int'(mc[k]) < cmax(k)) mc[k] <= mc[k] + 8'd1;
                end
            end else mo[k] <= 1'b0;
        end
    end
    task automatic cmp(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d t=%0t got=%h expected=%h", nm, k, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 4; k++) begin
                cmp("model_q", k, dq[k], mq[k]);
                cmp("model_overflow", k, {7'b0, dov[k]}, {7'b0, mo[k]});
                cmp("model_sticky", k, {7'b0, dst[k]}, {7'b0, ms[k]});
                cmp("model_count", k, dc[k], mc[k]);
            end
        end
    end
    task automatic drive(input logic r, input logic c, input logic e, input logic [7:0] dv);
        rst = r;
        clr = c;
        en  = e;
        d   = dv;
        @(posedge clk);
        #1;
    endtask
    task automatic lit(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        cmp(nm, k, act, exp);
    endtask
    initial begin
        drive(1, 0, 0, 8'h00);
        chk_on = 1'b1;
        lit("reset_q", 0, dq[0], 8'h00);
        lit("reset_count", 1, dc[1], 8'h00);
        drive(0, 0, 1, 8'hF0);
        lit("wrap_first_q", 0, dq[0], 8'hF0);
        lit("sat_first_q", 1, dq[1], 8'hF0);
        drive(0, 0, 1, 8'h20);
        lit("wrap_q", 0, dq[0], 8'h10);
        lit("wrap_ovf", 0, {7'b0, dov[0]}, 8'h01);
        lit("wrap_sticky", 0, {7'b0, dst[0]}, 8'h01);
        lit("wrap_count", 0, dc[0], 8'h01);
        lit("usat_q", 1, dq[1], 8'hFF);
        lit("usat_ovf", 1, {7'b0, dov[1]}, 8'h01);
        drive(0, 0, 1, 8'h01);
        lit("usat_again_q", 1, dq[1], 8'hFF);
        lit("usat_again_ovf", 1, {7'b0, dov[1]}, 8'h01);
        lit("usat_again_count", 1, dc[1], 8'h02);
        lit("wrap_pulse_end", 0, {7'b0, dov[0]}, 8'h00);
        drive(0, 1, 1, 8'h55);
        lit("clr_q", 0, dq[0], 8'h00);
        lit("clr_sticky", 0, {7'b0, dst[0]}, 8'h00);
        lit("clr_count", 1, dc[1], 8'h00);
        drive(0, 0, 1, 8'h7F);
        drive(0, 0, 1, 8'h01);
        lit("swrap_q", 2, dq[2], 8'h80);
        lit("swrap_ovf", 2, {7'b0, dov[2]}, 8'h01);
        lit("ssat_pos_q", 3, dq[3], 8'h7F);
        lit("ssat_pos_ovf", 3, {7'b0, dov[3]}, 8'h01);
        lit("unsigned_no_ovf", 0, {7'b0, dov[0]}, 8'h00);
        drive(0, 0, 1, 8'h7F);
        lit("swrap_mixed_q", 2, dq[2], 8'hFF);
        lit("swrap_mixed_ovf", 2, {7'b0, dov[2]}, 8'h00);
        drive(0, 1, 0, 8'h00);
        drive(0, 0, 1, 8'h80);
        drive(0, 0, 1, 8'hFF);
        lit("ssat_neg_q", 3, dq[3], 8'h80);
        lit("ssat_neg_ovf", 3, {7'b0, dov[3]}, 8'h01);
        drive(0, 1, 0, 8'h00);
        drive(0, 0, 1, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 8'hFF);
            lit("cnt_sat_ovf", 1, {7'b0, dov[1]}, 8'h01);
            lit("cnt_sat_count", 1, dc[1], (i < 3) ? 8'(i + 1) : 8'h03);
            lit("cnt_sat_sticky", 1, {7'b0, dst[1]}, 8'h01);
        end
        drive(0, 0, 1, 8'h33);
        drive(1, 0, 1, 8'h55);
        lit("rst_q", 0, dq[0], 8'h00);
        lit("rst_sticky", 1, {7'b0, dst[1]}, 8'h00);
        lit("rst_count", 1, dc[1], 8'h00);
        lit("rst_ovf", 1, {7'b0, dov[1]}, 8'h00);
        drive(0, 0, 1, 8'h03);
        lit("post_rst_q", 0, dq[0], 8'h03);
        drive(0, 0, 0, 8'h99);
        lit("hold_q", 0, dq[0], 8'h03);
        lit("hold_ovf", 0, {7'b0, dov[0]}, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] dv;
            int m;
            m  = $urandom_range(0, 3);
            dv = (m == 0) ? 8'($urandom_range(0, 15)) : (m == 1) ? 8'($urandom_range(240, 255)) :
                 (m == 2) ? 8'($urandom_range(112, 143)) : 8'($urandom);
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 75, dv);
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
